// File: rtl/modexp_stream.sv
// modexp_stream: handshaked m^e mod n engine using left-to-right square-and-multiply
// over a bit-serial interleaved radix-2 modular multiplier (WIDTH cycles per multiply).
module modexp_stream #(
    parameter int WIDTH     = 16,
    parameter int EXP_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     m,
    input  logic [EXP_WIDTH-1:0] e,
    input  logic [WIDTH-1:0]     n,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic                 err
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, SQR, MUL, HOLD} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH-1:0]     n_q, n_d;
    logic [EXP_WIDTH-1:0] e_q, e_d;
    logic [WIDTH-1:0]     r_q, r_d;      // running exponentiation value R
    logic [WIDTH-1:0]     p_q, p_d;      // multiplier partial product P
    logic [CW-1:0]        cnt_q, cnt_d;  // multiplier step counter
    logic [PW-1:0]        ptr_q, ptr_d;  // exponent bit pointer
    logic                 err_q, err_d;
    logic                 out_valid_q, out_valid_d;

    logic [WIDTH-1:0]     mul_b;
    logic [CW-1:0]        bit_idx;
    logic [WIDTH-1:0]     p_next;
    logic                 mul_last;
    logic [PW-1:0]        msb;

    // One interleaved step: P = (2P mod n + (bit ? a : 0)) mod n, each with one
    // conditional subtract; WIDTH+1 bits suffice because P, a < n.
    function automatic logic [WIDTH-1:0] mod_step(input logic [WIDTH-1:0] p,
                                                  input logic             b,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] md);
        logic [WIDTH:0] t;
        t = {p, 1'b0};
        if (t >= {1'b0, md}) t = t - {1'b0, md};
        if (b) t = t + {1'b0, a};
        if (t >= {1'b0, md}) t = t - {1'b0, md};
        return t[WIDTH-1:0];
    endfunction

    assign mul_b    = (state_q == MUL) ? m_q : r_q;
    assign bit_idx  = CW'(WIDTH - 1) - cnt_q;
    assign p_next   = mod_step(p_q, mul_b[bit_idx], r_q, n_q);
    assign mul_last = (cnt_q == CW'(WIDTH - 1));

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign result    = r_q;
    assign err       = err_q;

    // Locate the most significant set bit of the captured exponent.
    always_comb begin
        msb = '0;
        for (int i = 0; i < EXP_WIDTH; i++) begin
            if (e_q[i]) msb = PW'(i);
        end
    end

    // Next-state and datapath update for the control FSM.
    always_comb begin
        state_d     = state_q;
        m_d         = m_q;
        n_d         = n_q;
        e_d         = e_q;
        r_d         = r_q;
        p_d         = p_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    m_d     = m;
                    e_d     = e;
                    n_d     = n;
                    err_d   = 1'b0;
                    r_d     = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                p_d   = '0;
                cnt_d = '0;
                if ((n_q == '0) || (m_q >= n_q)) begin
                    err_d   = 1'b1;
                    r_d     = '0;
                    state_d = HOLD;
                end else if (e_q == '0) begin
                    r_d     = WIDTH'(n_q != WIDTH'(1));
                    state_d = HOLD;
                end else begin
                    // The exponent MSB is covered by R = m; scanning starts just below it.
                    r_d     = m_q;
                    ptr_d   = msb - PW'(1);
                    state_d = (msb == '0) ? HOLD : SQR;
                end
            end
            SQR, MUL: begin
                p_d   = p_next;
                cnt_d = cnt_q + CW'(1);
                if (mul_last) begin
                    p_d   = '0;
                    cnt_d = '0;
                    r_d   = p_next;
                    if (state_q == SQR && e_q[ptr_q]) begin
                        state_d = MUL;
                    end else if (ptr_q == '0) begin
                        state_d = HOLD;
                    end else begin
                        ptr_d   = ptr_q - PW'(1);
                        state_d = SQR;
                    end
                end
            end
            HOLD: begin
                // out_valid follows one cycle after HOLD is entered.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, all cleared by asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            m_q         <= '0;
            n_q         <= '0;
            e_q         <= '0;
            r_q         <= '0;
            p_q         <= '0;
            cnt_q       <= '0;
            ptr_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            n_q         <= n_d;
            e_q         <= e_d;
            r_q         <= r_d;
            p_q         <= p_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_modexp_stream.sv
// tb_modexp_stream: directed checks of modexp_stream results, latency, errors,
// backpressure and asynchronous reset.
module tb_modexp_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] m;
    logic [15:0] e;
    logic [15:0] n;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        err;

    int errors = 0;
    int checks = 0;

    modexp_stream #(.WIDTH(16), .EXP_WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .m         (m),
        .e         (e),
        .n         (n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Present operands when the engine is ready; returns #1 after the accept edge.
    task automatic start_op(input logic [15:0] mv, input logic [15:0] ev, input logic [15:0] nv,
                            input string tag);
        int w;
        w = 0;
        while (!in_ready && w < 300) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (w >= 300) chk({tag, "_accept_timeout"}, 32'(w), 32'(0));
        m        = mv;
        e        = ev;
        n        = nv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges from accept to out_valid and check result/err there.
    task automatic wait_out(input int lat, input logic [15:0] res, input logic er,
                            input string tag);
        int   cyc;
        logic busy_ok;
        cyc     = 0;
        busy_ok = 1'b1;
        while (cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
            if (out_valid) break;
            if (in_ready) busy_ok = 1'b0;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(lat));
        chk({tag, "_busy"}, 32'(busy_ok), 32'(1));
        chk({tag, "_result"}, 32'(result), 32'(res));
        chk({tag, "_err"}, 32'(err), 32'(er));
    endtask

    // With out_ready high, the next edge completes the handshake.
    task automatic handshake(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_ov_clr"}, 32'(out_valid), 32'(0));
        chk({tag, "_ready_back"}, 32'(in_ready), 32'(1));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        m         = '0;
        e         = '0;
        n         = '0;
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_result", 32'(result), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 9^3 mod 55 = 14; k=2, S=1, M=1 -> 1+32+1
        start_op(16'd9, 16'd3, 16'd55, "op9_3");
        wait_out(34, 16'd14, 1'b0, "op9_3");
        handshake("op9_3");

        // 4^13 mod 497 = 445; S=3, M=2 -> 82; then back-to-back 2^10 mod 1000 = 24
        start_op(16'd4, 16'd13, 16'd497, "op4_13");
        wait_out(82, 16'd445, 1'b0, "op4_13");
        handshake("op4_13");
        start_op(16'd2, 16'd10, 16'd1000, "op2_10");
        wait_out(66, 16'd24, 1'b0, "op2_10");
        handshake("op2_10");

        // e == 0
        start_op(16'd9, 16'd0, 16'd55, "e0_n55");
        wait_out(2, 16'd1, 1'b0, "e0_n55");
        handshake("e0_n55");
        start_op(16'd0, 16'd0, 16'd1, "e0_n1");
        wait_out(2, 16'd0, 1'b0, "e0_n1");
        handshake("e0_n1");

        // e == 1: only the MSB, no multiplies
        start_op(16'd5, 16'd1, 16'd7, "e1");
        wait_out(2, 16'd5, 1'b0, "e1");
        handshake("e1");

        // Illegal operands
        start_op(16'd0, 16'd5, 16'd0, "err_n0");
        wait_out(2, 16'd0, 1'b1, "err_n0");
        handshake("err_n0");
        start_op(16'd60, 16'd3, 16'd55, "err_mge");
        wait_out(2, 16'd0, 1'b1, "err_mge");
        handshake("err_mge");
        // 7^2 mod 55 = 49; S=1, M=0 -> 18
        start_op(16'd7, 16'd2, 16'd55, "after_err");
        wait_out(18, 16'd49, 1'b0, "after_err");
        handshake("after_err");

        // Backpressure with a pending request
        out_ready = 1'b0;
        start_op(16'd9, 16'd3, 16'd55, "bp");
        wait_out(34, 16'd14, 1'b0, "bp");
        m        = 16'd3;
        e        = 16'd5;
        n        = 16'd11;
        in_valid = 1'b1;
        begin
            logic stable_ok;
            stable_ok = 1'b1;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk);
                #1;
                if (out_valid !== 1'b1 || result !== 16'd14 || err !== 1'b0 || in_ready !== 1'b0)
                    stable_ok = 1'b0;
            end
            chk("bp_stable", 32'(stable_ok), 32'(1));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_ov_clr", 32'(out_valid), 32'(0));
        chk("bp_ready_back", 32'(in_ready), 32'(1));

        // Reset in the middle of an operation
        start_op(16'd4, 16'd13, 16'd497, "rst_mid");
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_out_valid", 32'(out_valid), 32'(0));
        chk("rst_mid_in_ready", 32'(in_ready), 32'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        start_op(16'd9, 16'd3, 16'd55, "post_rst");
        wait_out(34, 16'd14, 1'b0, "post_rst");
        handshake("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
